// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/if_perf_counters.sv
// Saturating stall / redirect event counters for the fetch unit (IF_FETCH_PERF_EN builds only).
module if_perf_counters
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] redirect_cnt_o
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  // Next-count selection: bump on event, saturating at all-ones.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall_i) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_i) begin
      redirect_cnt_d = sat_inc32(redirect_cnt_q);
    end else begin
      redirect_cnt_d = redirect_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= 32'h0000_0000;
      redirect_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage front end: owns the PC, fetches over a req/ack memory port and feeds IF/ID.
// Define IF_FETCH_PERF_EN to add the perf_stall_cnt / perf_redirect_cnt outputs.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] Branch_Address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] PC_out,
  output logic [31:0]       Instruction_out,
  output logic              valid_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [1:0]        rst_sync_q;
  logic              rst_sync_n;
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       ibuf_q, ibuf_d;
  logic [ADDR_W-1:0] pc_plus_s;

  // Reset synchroniser: asserts with rst, releases two clock edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];
  assign pc_plus_s  = pc_q + STEP;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ibuf_d     = ibuf_q;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        req_addr_d = pc_q;
      end
      FETCH: begin
        if (imem_ack && !Branch_taken) begin
          ibuf_d  = imem_rdata;
          state_d = VALID;
        end else if (imem_ack && Branch_taken) begin
          pc_d       = Branch_Address;
          req_addr_d = Branch_Address;
        end else if (Branch_taken) begin
          // Request already on the bus cannot be withdrawn; wait it out in DROP.
          pc_d    = Branch_Address;
          state_d = DROP;
        end else begin
          state_d = FETCH;
        end
      end
      DROP: begin
        if (Branch_taken) begin
          pc_d = Branch_Address;
        end else begin
          pc_d = pc_q;
        end
        if (imem_ack) begin
          req_addr_d = Branch_taken ? Branch_Address : pc_q;
          state_d    = FETCH;
        end else begin
          state_d = DROP;
        end
      end
      VALID: begin
        if (Branch_taken) begin
          pc_d       = Branch_Address;
          req_addr_d = Branch_Address;
          state_d    = FETCH;
        end else if (!freeze) begin
          pc_d       = pc_plus_s;
          req_addr_d = pc_plus_s;
          state_d    = FETCH;
        end else begin
          state_d = VALID;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ibuf_q     <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ibuf_q     <= ibuf_d;
    end
  end

  // Output decode from state and registers only; non-VALID states emit a bubble.
  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = '0;
    valid_out       = 1'b0;
    PC_out          = '0;
    Instruction_out = NOP_INSTR;
    case (state_q)
      FETCH, DROP: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end
      VALID: begin
        valid_out       = 1'b1;
        PC_out          = pc_plus_s;
        Instruction_out = ibuf_q;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

`ifdef IF_FETCH_PERF_EN
  if_perf_counters u_perf (
    .clk            (clk),
    .rst_n          (rst_sync_n),
    .stall_i        (~valid_out),
    .redirect_i     (Branch_taken),
    .stall_cnt_o    (perf_stall_cnt),
    .redirect_cnt_o (perf_redirect_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised scoreboard bench for if_fetch_unit: the bench plays memory and pipeline.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, Branch_taken, imem_ack, imem_req, valid_out;
  logic [31:0] Branch_Address, imem_addr, imem_rdata, PC_out, Instruction_out;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_redirect_cnt;
`endif

  if_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .Branch_taken    (Branch_taken),
    .Branch_Address  (Branch_Address),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .Instruction_out (Instruction_out),
    .valid_out       (valid_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Instruction memory contents; address 0 holds 32'hE3A01005.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hE3A0_1005;
  endfunction

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(3, 0))
      0:       return 32'hFFFF_FFFC;
      1:       return 32'hFFFF_FFF8;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } pres_t;
  pres_t exp_q[$];

  // Architectural model: one outstanding fetch, or one presented instruction.
  bit          m_out, m_pres, m_squash, after_reset;
  logic [31:0] m_next, m_reqaddr, m_pc;
  int          lat_left, gap, presented;
  // Stimulus knobs.
  int          lat_min, lat_max, frz_pct, bt_pct, frz_left;
  bit          no_ack, bt_on_valid, bt_arm_inflight;
  logic [31:0] bt_valid_tgt, bt_inflight_addr, bt_inflight_tgt;
  bit          mon_en = 1'b0;

  // Monitor: pops one expectation per presentation, checks it while held, checks bubbles otherwise.
  initial begin
    bit    prev_valid;
    pres_t held;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_valid = 1'b0;
      end else begin
        if (valid_out === 1'b1) begin
          if (!prev_valid) begin
            if (exp_q.size() == 0) begin
              check("valid_unexpected", 32'(valid_out), 32'h0);
              held = '0;
            end else begin
              held = exp_q.pop_front();
            end
          end
          check("pc_out", PC_out, held.pc4);
          check("instr_out", Instruction_out, held.instr);
        end else begin
          check("bubble_pc", PC_out, 32'h0);
          check("bubble_instr", Instruction_out, 32'h0);
        end
        prev_valid = (valid_out === 1'b1);
      end
    end
  end

  task automatic model_reset();
    m_out = 0; m_pres = 0; m_squash = 0; after_reset = 1;
    m_next = RESET_PC; m_reqaddr = 32'h0; m_pc = 32'h0;
    lat_left = 0; gap = 0;
    exp_q.delete();
  endtask

  task automatic step();
    bit ack;
    @(negedge clk);
    freeze = 1'b0; Branch_taken = 1'b0; Branch_Address = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("valid_state", 32'(valid_out), 32'(m_pres));
    if (m_pres) begin
      check("no_req_in_valid", 32'(imem_req), 32'h0);
      if (bt_on_valid) begin
        bt_on_valid = 0; Branch_taken = 1'b1; freeze = 1'b1; Branch_Address = bt_valid_tgt;
      end else if (frz_left > 0) begin
        frz_left--; freeze = 1'b1;
      end else begin
        freeze = ($urandom_range(99, 0) < frz_pct);
        if ($urandom_range(99, 0) < bt_pct) begin
          Branch_taken = 1'b1; Branch_Address = rand_tgt();
        end
      end
      if (Branch_taken) begin
        m_pres = 0; m_next = Branch_Address;
      end else if (!freeze) begin
        m_pres = 0; m_next = m_pc + 32'd4;
      end
    end else begin
      if (!m_out) begin
        if (imem_req === 1'b1) begin
          check("req_addr", imem_addr, m_next);
          m_out = 1; m_squash = 0; m_reqaddr = m_next; gap = 0; after_reset = 0;
          lat_left = $urandom_range(lat_max, lat_min);
        end else begin
          gap++;
          if (!after_reset || gap > 6) begin
            check("req_gap", 32'(gap), 32'h0);
            gap = 0;
          end
        end
      end else begin
        check("req_hold", 32'(imem_req), 32'h1);
        check("addr_stable", imem_addr, m_reqaddr);
      end
      if (m_out) begin
        freeze = ($urandom_range(99, 0) < frz_pct);
        if (bt_arm_inflight && m_reqaddr == bt_inflight_addr) begin
          bt_arm_inflight = 0; Branch_taken = 1'b1; Branch_Address = bt_inflight_tgt;
        end else if ($urandom_range(99, 0) < bt_pct) begin
          Branch_taken = 1'b1; Branch_Address = rand_tgt();
        end
        ack = !no_ack && (lat_left == 0);
        if (!ack && lat_left > 0) lat_left--;
        imem_ack = ack;
        if (ack) imem_rdata = mem_word(imem_addr);
        if (Branch_taken) begin
          m_squash = 1; m_next = Branch_Address;
        end
        if (ack) begin
          m_out = 0;
          if (!m_squash) begin
            exp_q.push_back('{pc4: m_reqaddr + 32'd4, instr: mem_word(m_reqaddr)});
            m_pres = 1; m_pc = m_reqaddr; presented++;
          end
        end
      end
    end
  endtask

  task automatic run_until_pres(input int n, input int budget);
    int start;
    start = presented;
    for (int i = 0; i < budget && presented < start + n; i++) step();
    check("progress", 32'(presented - start), 32'(n));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, 32'(valid_out), 32'h0);
    check({tag, "_pc"}, PC_out, 32'h0);
    check({tag, "_instr"}, Instruction_out, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; freeze = 1'b0; Branch_taken = 1'b0; Branch_Address = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    presented = 0; no_ack = 0; bt_on_valid = 0; bt_arm_inflight = 0;
    frz_left = 0; lat_min = 0; lat_max = 0; frz_pct = 0; bt_pct = 0;
    bt_valid_tgt = 32'h0; bt_inflight_addr = 32'h0; bt_inflight_tgt = 32'h0;
    model_reset();
    #2;
    check_quiet("reset0");
    repeat (3) @(negedge clk);
    check_quiet("reset1");
    rst = 1'b1; mon_en = 1'b1;

    // Zero-latency run with a 4-cycle freeze on the first instruction.
    frz_left = 4;
    run_until_pres(3, 40);

    // Three-cycle latency; branch to 0x80 while the fetch of 0x10 is in flight.
    lat_min = 3; lat_max = 3;
    bt_arm_inflight = 1; bt_inflight_addr = 32'h10; bt_inflight_tgt = 32'h80;
    run_until_pres(3, 80);
    check("inflight_branch_used", 32'(bt_arm_inflight), 32'h0);

    // Branch to 0x40 while presenting with freeze also high.
    lat_min = 0; lat_max = 0;
    bt_on_valid = 1; bt_valid_tgt = 32'h40;
    run_until_pres(2, 40);

    // Random traffic.
    lat_min = 0; lat_max = 3; frz_pct = 25; bt_pct = 10;
    repeat (600) step();

    // Asynchronous reset while a request is outstanding.
    frz_pct = 0; bt_pct = 0; no_ack = 1;
    for (int i = 0; i < 12 && !m_out; i++) step();
    step();
    check("req_before_rst", 32'(imem_req), 32'h1);
    #2;
    rst = 1'b0; mon_en = 1'b0;
    #1;
    check_quiet("async_rst");
    model_reset();
    no_ack = 0;
    repeat (2) @(negedge clk);
    check_quiet("rst_hold");
    rst = 1'b1; mon_en = 1'b1;
    lat_min = 0; lat_max = 2;
    run_until_pres(4, 60);

    // Drain: no more acks, let the monitor consume what is queued.
    no_ack = 1;
    repeat (4) step();
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
